// File: rtl/write_resp_channel_arbiter.sv
// write_resp_channel_arbiter: round-robin B-channel arbiter from two slave ports into a one-entry held response for the decoder.
module write_resp_channel_arbiter #(
   parameter int                         Num_Of_Masters  = 2,
   parameter int                         Master_ID_Width = $clog2(Num_Of_Masters),
   parameter logic [Master_ID_Width-1:0] M1_ID           = 'd0,
   parameter logic [Master_ID_Width-1:0] M2_ID           = 'd1
) (
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic [Master_ID_Width-1:0] M00_AXI_BID,
   input  logic [1:0]                 M00_AXI_bresp,
   input  logic                       M00_AXI_bvalid,
   output logic                       M00_AXI_bready,
   input  logic [Master_ID_Width-1:0] M01_AXI_BID,
   input  logic [1:0]                 M01_AXI_bresp,
   input  logic                       M01_AXI_bvalid,
   output logic                       M01_AXI_bready,
   input  logic                       S00_AXI_bready,
   input  logic                       S01_AXI_bready,
   output logic [Master_ID_Width-1:0] Sel_Resp_ID,
   output logic [1:0]                 Sel_Write_Resp,
   output logic                       Sel_Valid,
   output logic                       Resp_Drop_Err
);
   typedef enum logic {IDLE, HOLD} state_t;
   state_t                     r_state, w_next;
   logic                       r_ptr, r_drop;
   logic [Master_ID_Width-1:0] r_id;
   logic [1:0]                 r_resp;
   logic                       w_g0, w_g1, w_map0, w_map1, w_dst_rdy;
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) r_state <= IDLE;
      else          r_state <= w_next;
   always_comb begin
      w_map0    = r_id == M1_ID;
      w_map1    = r_id == M2_ID;
      w_dst_rdy = w_map0 ? S00_AXI_bready : (w_map1 ? S01_AXI_bready : 1'b0);
      w_g0      = r_state == IDLE && M00_AXI_bvalid && (!r_ptr || !M01_AXI_bvalid);
      w_g1      = r_state == IDLE && M01_AXI_bvalid && (r_ptr || !M00_AXI_bvalid);
      w_next    = r_state;
      if (r_state == IDLE && (w_g0 || w_g1)) w_next = HOLD;
      // an unmapped ID has no master to accept it, so it is released immediately
      if (r_state == HOLD && (w_dst_rdy || !(w_map0 || w_map1))) w_next = IDLE;
   end
   always_ff @(posedge ACLK or negedge ARESETN)
      if (!ARESETN) begin
         r_ptr  <= 1'b0;
         r_drop <= 1'b0;
         r_id   <= '0;
         r_resp <= 2'b00;
      end else begin
         r_drop <= r_state == HOLD && !(w_map0 || w_map1);
         if (w_g0) begin
            r_id   <= M00_AXI_BID;
            r_resp <= M00_AXI_bresp;
            r_ptr  <= 1'b1;
         end else if (w_g1) begin
            r_id   <= M01_AXI_BID;
            r_resp <= M01_AXI_bresp;
            r_ptr  <= 1'b0;
         end
      end
   assign M00_AXI_bready = w_g0 & ARESETN;
   assign M01_AXI_bready = w_g1 & ARESETN;
   assign Sel_Resp_ID    = r_id;
   assign Sel_Write_Resp = r_resp;
   assign Sel_Valid      = r_state == HOLD;
   assign Resp_Drop_Err  = r_drop;
endmodule

// File: tb/tb_write_resp_channel_arbiter.sv
// tb_write_resp_channel_arbiter: vector table, directed corner sequences and a randomized reference-model run.
module tb_write_resp_channel_arbiter;
   logic       clk, rst_n;
   logic       v0, v1, s0, s1;
   logic [1:0] id0, id1, r0, r1;
   logic       b0, b1, sv, drop;
   logic [1:0] sid, sresp;
   int         checks = 0, errors = 0;

   write_resp_channel_arbiter #(.Num_Of_Masters(4)) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .M00_AXI_BID(id0), .M00_AXI_bresp(r0), .M00_AXI_bvalid(v0), .M00_AXI_bready(b0),
      .M01_AXI_BID(id1), .M01_AXI_bresp(r1), .M01_AXI_bvalid(v1), .M01_AXI_bready(b1),
      .S00_AXI_bready(s0), .S01_AXI_bready(s1),
      .Sel_Resp_ID(sid), .Sel_Write_Resp(sresp), .Sel_Valid(sv), .Resp_Drop_Err(drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic v0; logic [1:0] id0, r0;
      logic v1; logic [1:0] id1, r1;
      logic s0, s1;
      logic b0, b1, sv; logic [1:0] sid, sresp; logic drop;
   } vec_t;
   vec_t vt[11];

   function automatic vec_t mk(input int a, ai, ar, b, bi, br, x0, x1, eb0, eb1, esv, esid, esr, ed);
      vec_t f;
      f.v0 = 1'(a);  f.id0 = 2'(ai); f.r0 = 2'(ar);
      f.v1 = 1'(b);  f.id1 = 2'(bi); f.r1 = 2'(br);
      f.s0 = 1'(x0); f.s1 = 1'(x1);
      f.b0 = 1'(eb0); f.b1 = 1'(eb1); f.sv = 1'(esv);
      f.sid = 2'(esid); f.sresp = 2'(esr); f.drop = 1'(ed);
      return f;
   endfunction

   task automatic chk(input string tag, input string n, input logic [1:0] act, input int exp);
      checks++;
      if (act !== 2'(exp)) begin
         errors++;
         $display("FAIL %s.%s got %0d expected %0d", tag, n, act, exp);
      end
   endtask

   task automatic expect_all(input string tag, input int eb0, eb1, esv, esid, esr, ed);
      chk(tag, "M00_bready", {1'b0, b0}, eb0);
      chk(tag, "M01_bready", {1'b0, b1}, eb1);
      chk(tag, "Sel_Valid", {1'b0, sv}, esv);
      chk(tag, "Sel_Resp_ID", sid, esid);
      chk(tag, "Sel_Write_Resp", sresp, esr);
      chk(tag, "Resp_Drop_Err", {1'b0, drop}, ed);
   endtask

   task automatic drive(input logic a, input logic [1:0] ai, ar, input logic b, input logic [1:0] bi, br, input logic x0, x1);
      v0 = a; id0 = ai; r0 = ar; v1 = b; id1 = bi; r1 = br; s0 = x0; s1 = x1;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // reference model: held entry plus "which slave goes first next time"
   bit       m_hold, m_ptr, m_drop;
   logic [1:0] m_id, m_resp;

   function automatic int pick();
      int order[2];
      order[0] = int'(m_ptr);
      order[1] = 1 - int'(m_ptr);
      if (m_hold) return -1;
      for (int i = 0; i < 2; i++)
         if ((order[i] == 0) ? v0 : v1) return order[i];
      return -1;
   endfunction

   task automatic model_edge(input int w);
      bit mapped, rdy;
      if (!m_hold) begin
         m_drop = 0;
         if (w >= 0) begin
            m_hold = 1;
            m_id   = (w == 0) ? id0 : id1;
            m_resp = (w == 0) ? r0 : r1;
            m_ptr  = (w == 0);
         end
      end else begin
         mapped = (m_id == 2'd0) || (m_id == 2'd1);
         rdy    = (m_id == 2'd0) ? s0 : ((m_id == 2'd1) ? s1 : 1'b0);
         m_drop = !mapped;
         if (!mapped || rdy) m_hold = 0;
      end
   endtask

   initial begin
      int w;
      vt[0]  = mk(1,0,0, 0,0,0, 1,0, 1,0,0,0,0,0);
      vt[1]  = mk(0,0,0, 0,0,0, 1,0, 0,0,1,0,0,0);
      vt[2]  = mk(1,1,2, 1,0,3, 1,1, 0,1,0,0,0,0);
      vt[3]  = mk(1,1,2, 0,0,0, 1,1, 0,0,1,0,3,0);
      vt[4]  = mk(1,1,2, 0,0,0, 1,1, 1,0,0,0,3,0);
      vt[5]  = mk(0,0,0, 0,0,0, 1,0, 0,0,1,1,2,0);
      vt[6]  = mk(0,0,0, 0,0,0, 0,1, 0,0,1,1,2,0);
      vt[7]  = mk(0,0,0, 1,3,1, 0,0, 0,1,0,1,2,0);
      vt[8]  = mk(0,0,0, 0,0,0, 0,0, 0,0,1,3,1,0);
      vt[9]  = mk(0,0,0, 0,0,0, 0,0, 0,0,0,3,1,1);
      vt[10] = mk(0,0,0, 0,0,0, 0,0, 0,0,0,3,1,0);

      do_reset();
      #1 expect_all("reset", 0, 0, 0, 0, 0, 0);
      adv();
      for (int i = 0; i < 11; i++) begin
         drive(vt[i].v0, vt[i].id0, vt[i].r0, vt[i].v1, vt[i].id1, vt[i].r1, vt[i].s0, vt[i].s1);
         #1 expect_all($sformatf("vec%0d", i), int'(vt[i].b0), int'(vt[i].b1), int'(vt[i].sv),
                       int'(vt[i].sid), int'(vt[i].sresp), int'(vt[i].drop));
         adv();
      end

      // both slaves always valid: grants must alternate starting at slave 0
      do_reset();
      drive(1, 1, 2, 1, 0, 3, 1, 1);
      for (int k = 0; k < 6; k++) begin
         #1 expect_all($sformatf("rr%0d_idle", k), int'(k % 2 == 0), int'(k % 2 == 1), 0,
                       (k == 0) ? 0 : ((k % 2 == 0) ? 0 : 1), (k == 0) ? 0 : ((k % 2 == 0) ? 3 : 2), 0);
         adv();
         #1 expect_all($sformatf("rr%0d_hold", k), 0, 0, 1, (k % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 2 : 3, 0);
         adv();
      end

      // ID 1 held while its master stalls; both slaves keep bvalid
      drive(1, 1, 1, 1, 0, 3, 1, 0);
      #1 chk("stall", "grant0", {1'b0, b0}, 1);
      adv();
      v0 = 1'b0;
      v1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 expect_all($sformatf("stall%0d", k), 0, 0, 1, 1, 1, 0);
         adv();
      end
      s0 = 1'b0;
      s1 = 1'b1;
      #1 chk("stall_rel", "Sel_Valid", {1'b0, sv}, 1);
      adv();
      #1 expect_all("after_rel", 0, 1, 0, 1, 1, 0);
      adv();
      v1 = 1'b0;
      // ID 0 held: only S00 ready may release it
      for (int k = 0; k < 3; k++) begin
         #1 expect_all($sformatf("wrong_rdy%0d", k), 0, 0, 1, 0, 3, 0);
         adv();
      end
      s0 = 1'b1;
      #1 chk("right_rdy", "Sel_Valid", {1'b0, sv}, 1);
      adv();
      #1 chk("right_rdy_done", "Sel_Valid", {1'b0, sv}, 0);
      adv();

      // asynchronous reset while holding
      do_reset();
      drive(1, 1, 2, 0, 0, 0, 0, 0);
      adv();
      #1 expect_all("pre_arst", 0, 0, 1, 1, 2, 0);
      v1 = 1'b1;
      #2 rst_n = 1'b0;
      #1 expect_all("arst", 0, 0, 0, 0, 0, 0);
      adv();
      #1 expect_all("arst_hold", 0, 0, 0, 0, 0, 0);
      adv();
      rst_n = 1'b1;
      #1 expect_all("arst_restart", 1, 0, 0, 0, 0, 0);
      adv();

      // randomized run against the reference model
      do_reset();
      m_hold = 0; m_ptr = 0; m_drop = 0; m_id = 2'd0; m_resp = 2'd0;
      for (int c = 0; c < 2000; c++) begin
         if (!v0 && $urandom_range(2) == 0) begin
            v0 = 1'b1; id0 = 2'($urandom_range(3)); r0 = 2'($urandom_range(3));
         end
         if (!v1 && $urandom_range(2) == 0) begin
            v1 = 1'b1; id1 = 2'($urandom_range(3)); r1 = 2'($urandom_range(3));
         end
         s0 = 1'($urandom_range(1));
         s1 = 1'($urandom_range(1));
         #1;
         w = pick();
         expect_all($sformatf("rnd%0d", c), int'(w == 0), int'(w == 1), int'(m_hold),
                    int'(m_id), int'(m_resp), int'(m_drop));
         @(posedge clk);
         model_edge(w);
         #1;
         if (w == 0) v0 = 1'b0;
         if (w == 1) v1 = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
